mix_columns_seq: RTL and testbench

Sequential, parametrised AES MixColumns / InvMixColumns engine for a full 128-bit state. It accepts one state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It returns the mixed state over a second valid/ready handshake. It sits in the round datapath between ShiftRows and AddRoundKey. It replaces per-byte combinational column mixing with a throttleable, mode-selectable unit.

---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/mix_column_unit.sv | 38 +++
 rtl/mix_columns_seq.sv | 114 +++++++++++
 tb/tb_mix_columns_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns datapath.
// Every multiply is an xtime chain plus XOR, so no lookup tables are inferred.
package aes_pkg;

  typedef logic [31:0]  col_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Multiply by x (0x02) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] x);
    gmul2 = xtime(x);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] x);
    gmul3 = xtime(x) ^ x;
  endfunction

  // 9 = 8 + 1
  function automatic logic [7:0] gmul9(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul9 = x8 ^ x;
  endfunction

  // 11 = 8 + 2 + 1
  function automatic logic [7:0] gmul11(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul11 = x8 ^ x2 ^ x;
  endfunction

  // 13 = 8 + 4 + 1
  function automatic logic [7:0] gmul13(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul13 = x8 ^ x4 ^ x;
  endfunction

  // 14 = 8 + 4 + 2
  function automatic logic [7:0] gmul14(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul14 = x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational mixing of one 32-bit column, forward or inverse.
// Row 0 of the column sits in the most significant byte.
module mix_column_unit
  import aes_pkg::*;
(
  input  col_t col_i,
  input  logic inverse_i,
  output col_t col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] f0, f1, f2, f3;
  logic [7:0] r0, r1, r2, r3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Forward matrix: rows of {02,03,01,01} rotated right by the row number.
  always_comb begin
    f0 = gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3;
    f1 = a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3;
    f2 = a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3);
    f3 = gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3);
  end

  // Inverse matrix: rows of {0E,0B,0D,09} rotated the same way.
  always_comb begin
    r0 = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    r1 = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    r2 = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    r3 = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
  end

  assign col_o = inverse_i ? {r0, r1, r2, r3} : {f0, f1, f2, f3};

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns / InvMixColumns engine for a full 128-bit AES state.
// One state is accepted, mixed COLS_PER_CYCLE columns per clock in place,
// then held on the output until the consumer takes it.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inverse,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int C = COLS_PER_CYCLE;

  // The counter is two bits wide, so C=4 steps by zero and finishes at once.
  localparam logic [1:0] CNT_STEP = 2'(C);
  localparam logic [1:0] CNT_LAST = 2'(4 - C);

  if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  fsm_e       state_q;
  logic [1:0] cnt_q;
  logic       mode_q;
  state_t     work_q;
  state_t     work_d;
  logic       in_ready_q;
  logic       out_valid_q;

  logic [1:0] col_idx [C];
  col_t       col_in  [C];
  col_t       col_out [C];

  // Column c lives at bit offset 32*(3-c); for a 2-bit c that is {~c, 5'b0}.
  for (genvar g = 0; g < C; g++) begin : g_mix
    assign col_idx[g] = cnt_q + 2'(g);
    assign col_in[g]  = work_q[{~col_idx[g], 5'b0} +: 32];

    mix_column_unit u_mix (
      .col_i     (col_in[g]),
      .inverse_i (mode_q),
      .col_o     (col_out[g])
    );
  end

  // Overwrite the columns being processed this cycle with their mixed values.
  always_comb begin
    work_d = work_q;
    for (int g = 0; g < C; g++) begin
      work_d[{~col_idx[g], 5'b0} +: 32] = col_out[g];
    end
  end

  // Control FSM with registered handshake outputs, plus the working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      mode_q      <= 1'b0;
      work_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            work_q     <= state_in;
            mode_q     <= inverse;
            cnt_q      <= 2'd0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        BUSY: begin
          work_q <= work_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= 2'd0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign state_out = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2 and 4 columns per cycle)
// against a matrix-product reference model over GF(2^8).
module tb_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         inverse   [3];
  logic [127:0] state_in  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] state_out [3];

  int checks;
  int errors;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .inverse   (inverse[g]),
      .state_in  (state_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .state_out (state_out[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic shift-and-add multiply in GF(2^8).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product per column: out[r] = XOR_k base[(k-r) mod 4] * in[k].
  function automatic logic [127:0] model_mix(input logic [127:0] st, input logic inv);
    logic [7:0]   base [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [127:0] res;
    if (inv) begin
      base[0] = 8'h0E; base[1] = 8'h0B; base[2] = 8'h0D; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = st[127 - 8 * (4 * c + k) -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gf_mul(base[(k - r + 4) % 4], a[k]);
        res[127 - 8 * (4 * c + r) -: 8] = b;
      end
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full transaction on instance i: accept, measure latency, release.
  // After accept, state_in and inverse are scrambled to show they are not re-sampled.
  task automatic xfer(input int i, input logic [127:0] st, input logic inv,
                      output logic [127:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready[i] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_ready", 128'(in_ready[i]), 128'(1));
    in_valid[i] = 1'b1;
    state_in[i] = st;
    inverse[i]  = inv;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    state_in[i] = ~st;
    inverse[i]  = ~inv;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid[i] && lat < 20);
    res = state_out[i];
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
    chk("release_in_ready", 128'(in_ready[i]), 128'(1));
    chk("release_out_valid", 128'(out_valid[i]), 128'(0));
  endtask

  typedef struct {
    logic [127:0] st;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    logic [127:0] res2;
    logic [127:0] st;
    logic [127:0] held;
    logic         inv;
    int           lat;
    int           w;

    checks = 0;
    errors = 0;

    tbl[0] = '{128'hDB135345_F20A225C_01010101_C6C6C6C6, 1'b0,
               128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6};
    tbl[1] = '{128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6, 1'b1,
               128'hDB135345_F20A225C_01010101_C6C6C6C6};
    tbl[2] = '{128'hD4D4D4D5_2D26314C_DB135345_F20A225C, 1'b0,
               128'hD5D5D7D6_4D7EBDF8_8E4DA1BC_9FDC589D};
    tbl[3] = '{128'hD5D5D7D6_4D7EBDF8_8E4DA1BC_9FDC589D, 1'b1,
               128'hD4D4D4D5_2D26314C_DB135345_F20A225C};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      inverse[i]   = 1'b0;
      state_in[i]  = '0;
      out_ready[i] = 1'b0;
    end

    // Reset state while rst_n is held low across clock edges.
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", 128'(in_ready[i]), 128'(0));
      chk("reset_out_valid", 128'(out_valid[i]), 128'(0));
      chk("reset_state_out", state_out[i], 128'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk("post_reset_in_ready", 128'(in_ready[i]), 128'(1));

    // Known-answer vectors on every instance, with latency 4/C.
    for (int v = 0; v < 4; v++) begin
      chk("model_known_answer", model_mix(tbl[v].st, tbl[v].inv), tbl[v].exp);
      for (int i = 0; i < 3; i++) begin
        xfer(i, tbl[v].st, tbl[v].inv, res, lat);
        chk("table_result", res, tbl[v].exp);
        chk("table_latency", 128'(lat), 128'(4 >> i));
      end
    end

    // Randomized states and modes against the reference model.
    for (int n = 0; n < 24; n++) begin
      st  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      xfer(n % 3, st, inv, res, lat);
      chk("random_result", res, model_mix(st, inv));
      chk("random_latency", 128'(lat), 128'(4 >> (n % 3)));
    end

    // Back-to-back mode switch: forward then inverse must round-trip.
    for (int i = 0; i < 3; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      xfer(i, st, 1'b0, res, lat);
      chk("switch_forward", res, model_mix(st, 1'b0));
      xfer(i, res, 1'b1, res2, lat);
      chk("switch_inverse", res2, st);
    end

    // Backpressure on C=1: hold DONE for 10 cycles with in_valid asserted.
    st = tbl[2].st;
    in_valid[0] = 1'b1;
    state_in[0] = st;
    inverse[0]  = 1'b0;
    @(posedge clk); #1;
    state_in[0] = tbl[1].st;
    inverse[0]  = 1'b1;
    w = 0;
    while (!out_valid[0] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_reached_done", 128'(out_valid[0]), 128'(1));
    held = state_out[0];
    chk("bp_result", held, tbl[2].exp);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_state_stable", state_out[0], held);
      chk("bp_in_ready_low", 128'(in_ready[0]), 128'(0));
      chk("bp_out_valid_high", 128'(out_valid[0]), 128'(1));
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("bp_idle_in_ready", 128'(in_ready[0]), 128'(1));
    chk("bp_idle_out_valid", 128'(out_valid[0]), 128'(0));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("bp_second_accept", 128'(in_ready[0]), 128'(0));
    w = 0;
    while (!out_valid[0] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_second_result", state_out[0], tbl[1].exp);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Reset asserted during the second BUSY cycle of a C=1 run.
    in_valid[0] = 1'b1;
    state_in[0] = tbl[0].st;
    inverse[0]  = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 128'(out_valid[0]), 128'(0));
    chk("midreset_state_out", state_out[0], 128'h0);
    chk("midreset_in_ready", 128'(in_ready[0]), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset_recover_ready", 128'(in_ready[0]), 128'(1));
    chk("midreset_recover_valid", 128'(out_valid[0]), 128'(0));
    xfer(0, tbl[0].st, 1'b0, res, lat);
    chk("midreset_fresh_result", res, tbl[0].exp);
    chk("midreset_fresh_latency", 128'(lat), 128'(4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
